// File: rtl/jt49_noise_chk_pkg.sv
// Shared constants, state encoding and predictor for the 17-bit PSG noise LFSR checker.
package jt49_noise_chk_pkg;

  localparam int POLY_LEN = 17;
  localparam int TAP      = 3;

  typedef enum logic [1:0] {
    FILL   = 2'd0,
    VERIFY = 2'd1,
    LOCKED = 2'd2
  } chk_state_e;

  // The all-zero term reproduces the generator's zero-lockout insertion.
  function automatic logic lfsr17_pred(input logic [POLY_LEN-1:0] w);
    return w[0] ^ w[TAP] ^ (w == '0);
  endfunction

endpackage

// File: rtl/jt49_sat_cnt.sv
// Saturating up-counter with synchronous clear; clear wins over a simultaneous increment.
module jt49_sat_cnt #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         cen,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q, count_d;

  // NOTE: every path assigns count_d first, so no latch is inferred.
  always_comb begin
    count_d = count_q;
    if (cen) begin
      if (clr)                         count_d = '0;
      else if (inc && count_q != '1)   count_d = count_q + W'(1);
    end
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
  end

  assign count = count_q;

endmodule

// File: rtl/jt49_noise_chk.sv
// Receive-side checker: self-synchronises a local copy of the 17-bit noise LFSR and
// reports lock status plus mispredictions seen while locked.
module jt49_noise_chk
  import jt49_noise_chk_pkg::*;
#(
  parameter int LOCK_CNT  = 32,
  parameter int ERR_LIMIT = 4,
  parameter int CW        = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          cen,
  input  logic          noise_in,
  input  logic          noise_vld,
  input  logic          clr_cnt,
  output logic          locked,
  output logic          err,
  output logic [CW-1:0] err_cnt
);

  chk_state_e          state_q, state_d;
  logic [4:0]          fill_q, fill_d;
  logic [7:0]          match_q, match_d;
  logic [3:0]          miss_q, miss_d;
  logic [POLY_LEN-1:0] win_q, win_d;
  logic                err_q, err_d;
  logic                acc, bit_in, pred, hit, inc;

  assign acc    = cen & noise_vld;
  assign bit_in = ~noise_in;
  assign pred   = lfsr17_pred(win_q);
  assign hit    = (bit_in == pred);

  always_comb begin
    state_d = state_q;
    fill_d  = fill_q;
    match_d = match_q;
    miss_d  = miss_q;
    win_d   = win_q;
    inc     = 1'b0;
    // err is a one-cen pulse: any enabled edge clears it unless a new miss occurs.
    err_d   = cen ? 1'b0 : err_q;
    if (acc) begin
      case (state_q)
        FILL: begin
          win_d = {bit_in, win_q[POLY_LEN-1:1]};
          if (fill_q == 5'(POLY_LEN - 1)) begin
            state_d = VERIFY;
            fill_d  = '0;
            match_d = '0;
          end else begin
            fill_d = fill_q + 5'd1;
          end
        end
        VERIFY: begin
          win_d = {bit_in, win_q[POLY_LEN-1:1]};
          if (!hit) begin
            state_d = FILL;
            fill_d  = '0;
          end else if (match_q == 8'(LOCK_CNT - 1)) begin
            state_d = LOCKED;
            miss_d  = '0;
          end else begin
            match_d = match_q + 8'd1;
          end
        end
        LOCKED: begin
          // Flywheel: shift the prediction so isolated line errors never reach the window.
          win_d = {pred, win_q[POLY_LEN-1:1]};
          if (hit) begin
            miss_d = '0;
          end else begin
            err_d = 1'b1;
            inc   = 1'b1;
            if (miss_q == 4'(ERR_LIMIT - 1)) begin
              state_d = FILL;
              fill_d  = '0;
              miss_d  = '0;
            end else begin
              miss_d = miss_q + 4'd1;
            end
          end
        end
        default: state_d = FILL;
      endcase
    end
  end

  // NOTE: the window is a handful of flops, so it is reset along with the control state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= FILL;
      fill_q  <= '0;
      match_q <= '0;
      miss_q  <= '0;
      win_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      fill_q  <= fill_d;
      match_q <= match_d;
      miss_q  <= miss_d;
      win_q   <= win_d;
      err_q   <= err_d;
    end
  end

  jt49_sat_cnt #(.W(CW)) u_err_cnt (
    .clk   (clk),
    .rst   (rst),
    .cen   (cen),
    .clr   (clr_cnt),
    .inc   (inc),
    .count (err_cnt)
  );

  assign locked = (state_q == LOCKED);
  assign err    = err_q;

endmodule

// File: tb/tb_jt49_noise_chk.sv
// Scoreboard bench for jt49_noise_chk: a generator model drives strobes, expected
// outputs are queued per strobe and a monitor compares after each accepted edge.
module tb_jt49_noise_chk;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cen = 1'b0;
  logic          noise_in = 1'b1;
  logic          noise_vld = 1'b0;
  logic          clr_cnt = 1'b0;
  logic          locked;
  logic          err;
  logic [CW-1:0] err_cnt;

  typedef struct packed {
    logic          locked;
    logic          err;
    logic [CW-1:0] cnt;
  } exp_t;

  exp_t        sb_q[$];
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [16:0] poly     = '0;
  logic        acc_q    = 1'b0;

  jt49_noise_chk #(.LOCK_CNT(32), .ERR_LIMIT(4), .CW(CW)) dut (
    .clk       (clk),
    .rst       (rst),
    .cen       (cen),
    .noise_in  (noise_in),
    .noise_vld (noise_vld),
    .clr_cnt   (clr_cnt),
    .locked    (locked),
    .err       (err),
    .err_cnt   (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: one pop per accepted strobe, sampled on the falling edge.
  always @(posedge clk) acc_q <= cen & noise_vld;

  always @(negedge clk) begin
    exp_t e;
    if (acc_q) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL scoreboard_empty actual=strobe expected=none at %0t", $time);
      end else begin
        e = sb_q.pop_front();
        check("locked",  32'(locked),  32'(e.locked));
        check("err",     32'(err),     32'(e.err));
        check("err_cnt", 32'(err_cnt), 32'(e.cnt));
      end
    end
  end

  // One accepted generator bit (optionally inverted on the line), then an idle cen cycle.
  task automatic strobe(input bit flip, input bit clr, input bit e_locked, input bit e_err,
                        input int e_cnt);
    exp_t e;
    @(negedge clk);
    cen       = 1'b1;
    noise_vld = 1'b1;
    clr_cnt   = clr;
    noise_in  = ~(poly[0] ^ flip);
    e.locked  = e_locked;
    e.err     = e_err;
    e.cnt     = CW'(e_cnt);
    sb_q.push_back(e);
    poly = {poly[0] ^ poly[3] ^ (poly == '0), poly[16:1]};
    @(negedge clk);
    noise_vld = 1'b0;
    clr_cnt   = 1'b0;
  endtask

  // Asynchronous reset with cen low; outputs must clear before any clock edge.
  task automatic async_reset(input string tag);
    @(negedge clk);
    cen = 1'b0;
    #2 rst = 1'b1;
    #1;
    check({tag, "_locked"},  32'(locked),  32'd0);
    check({tag, "_err"},     32'(err),     32'd0);
    check({tag, "_err_cnt"}, 32'(err_cnt), 32'd0);
    @(negedge clk);
    rst  = 1'b0;
    cen  = 1'b1;
    poly = '0;
  endtask

  task automatic hold_cen_low(input bit e_locked, input int e_cnt);
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      cen       = 1'b0;
      noise_vld = 1'b1;
      clr_cnt   = 1'b1;
      noise_in  = 1'($urandom);
    end
    @(negedge clk);
    check("hold_locked",  32'(locked),  32'(e_locked));
    check("hold_err",     32'(err),     32'd0);
    check("hold_err_cnt", 32'(err_cnt), 32'(e_cnt));
    noise_vld = 1'b0;
    clr_cnt   = 1'b0;
    cen       = 1'b1;
  endtask

  initial begin
    #1 check("rst_locked", 32'(locked), 32'd0);
    check("rst_err",     32'(err),     32'd0);
    check("rst_err_cnt", 32'(err_cnt), 32'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    cen = 1'b1;

    // Clean acquisition: lock on strobe 49.
    for (int n = 1; n <= 49; n++) strobe(0, 0, n == 49, 0, 0);

    // Single line error at strobe 100, then 50 clean strobes.
    for (int n = 50; n <= 99; n++) strobe(0, 0, 1, 0, 0);
    strobe(1, 0, 1, 1, 1);
    for (int n = 0; n < 50; n++) strobe(0, 0, 1, 0, 1);

    // Four consecutive errors drop lock; relock 49 clean strobes later.
    for (int k = 1; k <= 4; k++) strobe(1, 0, k < 4, 1, 1 + k);
    for (int k = 1; k <= 49; k++) strobe(0, 0, k == 49, 0, 5);

    // Isolated errors saturate the 4-bit counter at 15.
    for (int i = 1; i <= 20; i++) begin
      strobe(1, 0, 1, 1, (5 + i > 15) ? 15 : 5 + i);
      strobe(0, 0, 1, 0, (5 + i > 15) ? 15 : 5 + i);
      strobe(0, 0, 1, 0, (5 + i > 15) ? 15 : 5 + i);
    end
    strobe(1, 1, 1, 1, 0);
    strobe(0, 0, 1, 0, 0);
    strobe(1, 0, 1, 1, 1);
    strobe(0, 0, 1, 0, 1);

    // Reset while locked; then a VERIFY-phase mismatch at strobe 47.
    async_reset("rst_locked");
    for (int n = 1; n <= 46; n++) strobe(0, 0, 0, 0, 0);
    strobe(1, 0, 0, 0, 0);
    for (int k = 1; k <= 49; k++) strobe(0, 0, k == 49, 0, 0);

    // cen low while locked: no strobe consumed, no clear, nothing moves.
    strobe(1, 0, 1, 1, 1);
    strobe(0, 0, 1, 0, 1);
    hold_cen_low(1, 1);
    for (int n = 0; n < 5; n++) strobe(0, 0, 1, 0, 1);

    // Reset mid-VERIFY, then cen low with strobes held; lock still needs exactly 49.
    async_reset("rst_verify_pre");
    for (int n = 1; n <= 27; n++) strobe(0, 0, 0, 0, 0);
    async_reset("rst_verify");
    hold_cen_low(0, 0);
    for (int k = 1; k <= 49; k++) strobe(0, 0, k == 49, 0, 0);

    repeat (3) @(negedge clk);
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
